// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_out_buffer.sv
// Two-entry decode-facing buffer: a visible output entry backed by one skid
// entry that catches a response arriving while decode is stalled.
module fetch_out_buffer
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_data,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  output logic [XLEN-1:0] out_data,
  output logic [XLEN-1:0] out_pc,
  output logic            skid_valid
);

  logic            out_valid_reg;
  logic [XLEN-1:0] out_data_reg;
  logic [XLEN-1:0] out_pc_reg;
  logic            skid_valid_reg;
  logic [XLEN-1:0] skid_data_reg;
  logic [XLEN-1:0] skid_pc_reg;
  logic            advance;

  assign advance = !out_valid_reg || !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= NOP_INSTR;
      out_pc_reg     <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= NOP_INSTR;
      skid_pc_reg    <= '0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (advance) begin
      if (skid_valid_reg) begin
        // Older skid entry goes first so program order is preserved.
        out_valid_reg  <= 1'b1;
        out_data_reg   <= skid_data_reg;
        out_pc_reg     <= skid_pc_reg;
        skid_valid_reg <= in_valid;
        if (in_valid) begin
          skid_data_reg <= in_data;
          skid_pc_reg   <= in_pc;
        end
      end else if (in_valid) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= in_data;
        out_pc_reg    <= in_pc;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (in_valid) begin
      skid_valid_reg <= 1'b1;
      skid_data_reg  <= in_data;
      skid_pc_reg    <= in_pc;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_pc     = out_pc_reg;
  assign skid_valid = skid_valid_reg;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one request at a
// time to instruction memory and squashes responses fetched down a stale path.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_src,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc_out
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] req_pc_reg, req_pc_next;
  logic            drop_reg, drop_next;
  logic            skid_valid;
  logic            req_fire;
  logic            resp_fire;
  logic            deliver;
  logic            unused_target_lsbs;

  assign unused_target_lsbs = ^branch_target[1:0];

  // No new request while the skid holds data: that bounds occupancy at two.
  assign imem_req_valid = (state_reg == S_REQ) && !skid_valid;
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_fire      = (state_reg == S_WAIT) && imem_resp_valid;
  assign deliver        = resp_fire && !drop_reg && !pc_src;

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req_pc_next   = req_pc_reg;
    drop_next     = drop_reg;
    case (state_reg)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (req_fire) begin
          state_next    = S_WAIT;
          req_pc_next   = fetch_pc_reg;
          fetch_pc_next = fetch_pc_reg + STEP;
          drop_next     = pc_src;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          state_next = S_REQ;
          drop_next  = 1'b0;
        end else if (pc_src) begin
          drop_next = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // A redirect overrides any sequential advance made above.
    if (pc_src) begin
      fetch_pc_next = {branch_target[XLEN-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= RESET_PC;
      drop_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      req_pc_reg   <= req_pc_next;
      drop_reg     <= drop_next;
    end
  end

  fetch_out_buffer u_out_buffer (
    .clk        (clk),
    .rst        (rst),
    .flush      (pc_src),
    .stall      (stall),
    .in_valid   (deliver),
    .in_data    (imem_resp_data),
    .in_pc      (req_pc_reg),
    .out_valid  (if_valid),
    .out_data   (instruction),
    .out_pc     (pc_out),
    .skid_valid (skid_valid)
  );

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencing controller for the instruction-fetch stage of the 32-bit RISC-V core. Owns the fetch PC, drives a valid/ready request channel and a valid response channel to instruction memory, and presents fetched instructions to decode through a 2-entry output buffer that absorbs decode stalls. Applies branch redirects from execute, and discards any in-flight response fetched down the wrong path.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- PC_STEP, 4, sequential PC increment in bytes

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- pc_src  in  1  redirect pulse from execute; 1 = take branch_target
- branch_target  in  32  redirect address; bits [1:0] ignored (forced 00)
- stall  in  1  decode cannot accept this cycle
- imem_req_valid  out  1  request valid
- imem_req_addr  out  32  request address
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  response valid, exactly one per accepted request
- imem_resp_data  in  32  fetched instruction word
- if_valid  out  1  instruction/pc_out valid to decode
- instruction  out  32  fetched instruction
- pc_out  out  32  address of instruction

## Operation
- FSM states: S_IDLE, S_REQ, S_WAIT. Reset state S_IDLE; S_IDLE -> S_REQ unconditionally.
- Registers: fetch_pc (reset RESET_PC), req_pc, drop flag (reset 0), output entry {if_valid, instruction, pc_out}, skid entry {skid_valid, data, pc}.
- S_REQ: imem_req_valid = !skid_valid; imem_req_addr = fetch_pc. Handshake (valid & ready) -> req_pc <= fetch_pc, fetch_pc <= fetch_pc + PC_STEP (wraps mod 2^32), go S_WAIT.
- S_WAIT: imem_req_valid = 0. On imem_resp_valid: if drop, clear drop and discard data; else deliver {data, req_pc}. Either way go S_REQ.
- At most one request outstanding.
- Output entry advances when !if_valid | !stall:
  - Skid is loaded first if valid.
  - Otherwise a delivered response is loaded.
  - Otherwise if_valid <= 0.
- Delivered response when the output entry cannot advance -> skid. S_REQ never issues while skid_valid, so the skid never overflows.
- Redirect (pc_src = 1) has priority over stall and all other events. At that edge:
  - fetch_pc <= {branch_target[31:2], 2'b00}.
  - if_valid <= 0; skid_valid <= 0.
  - S_REQ, no handshake: stay S_REQ. The address changes next cycle; this is legal because no handshake occurred.
  - S_REQ with handshake: go S_WAIT with drop <= 1.
  - S_WAIT, no response: stay S_WAIT with drop <= 1.
  - S_WAIT with response: discard it, drop <= 0, go S_REQ.
  - S_IDLE: go S_REQ using the new fetch_pc.
- Repeated redirects while drop = 1 keep drop = 1; only the last target is fetched.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, if_valid 0, instruction 32'h0000_0013 (NOP), pc_out 0.
- First request: imem_req_valid asserts in the 2nd cycle after rst deasserts (S_IDLE, then S_REQ).
- imem_resp_valid is sampled only in S_WAIT, i.e. no earlier than 1 cycle after the request handshake.
- Response to if_valid: 1 cycle when the output entry can advance.
- Peak throughput: one instruction every 2 cycles with 1-cycle memory.
- Redirect to request of target: the cycle after pc_src when in S_REQ or S_IDLE; the cycle after the old response retires when in S_WAIT.
- rst asserted mid-operation: all state returns to reset values at the next edge. A response arriving after reset that belongs to a pre-reset request is the memory's responsibility; memory is reset on the same rst.
- imem_req_valid stays high until handshake; imem_req_addr changes while valid only on redirect.

## Structure
- Package fetch_pkg:
  - fetch_state_t enum {S_IDLE, S_REQ, S_WAIT}
  - XLEN = 32
  - NOP_INSTR = 32'h0000_0013
- One sub-module, fetch_out_buffer: output entry plus skid entry, stall/flush handling, 2-entry occupancy.
- FSM, PC and drop logic stay in fetch_controller.

## Test plan
- Reset release, memory always ready, 1-cycle response data = addr: pc_out sequence 0x0, 0x4, 0x8; instruction equals pc_out; if_valid every other cycle.
- stall held 6 cycles during streaming: output holds its value, skid fills once, imem_req_valid stays 0 while skid full; on release 0x8 then 0xC are delivered in order, no loss or duplication.
- pc_src with target 0x103 while in S_WAIT: old response discarded; next request address 0x100; next if_valid has pc_out 0x100.
- pc_src in the same cycle as imem_resp_valid and stall = 1: if_valid drops to 0 next cycle, skid cleared, request to target follows.
- fetch_pc = 0xFFFF_FFFC: next sequential request address 0x0000_0000.
- rst pulsed while S_WAIT with full buffers: next cycle if_valid = 0, instruction = NOP, imem_req_valid = 0, then a request to RESET_PC.
